ir_window_ctrl: RTL
===================

// Module: ir_window_ctrl
// PURPOSE
// - Owns the 16-byte instruction window IR[127:0] feeding decode; byte0 = IR[127:120].
// - Accepts 8-byte fetch chunks, retires decoded instructions by left-shifting the window.
// - Drives the displacement mux selects (disp_sel, disp_size) for the current instruction.
// - Sits between the fetch queue and the decode stage; the length decoder is external.
// PARAMETERS
// - WIN_BYTES    16  window depth in bytes (IR width = 8*WIN_BYTES)
// - FETCH_BYTES   8  bytes per fetch chunk; FETCH_BYTES <= WIN_BYTES/2
// PORTS
// - CLK          in   1    clock, rising edge
// - CLR          in   1    asynchronous reset, active low
// - fetch_valid  in   1    fetch chunk present
// - fetch_data   in   64   chunk; byte0 = [63:56] = earliest in program order
// - fetch_ready  out  1    window can accept a chunk this cycle
// - flush        in   1    redirect: discard window contents and any same-cycle chunk
// - len_valid    in   1    instr_len/disp_* valid for bytes currently at IR head
// - instr_len    in   4    current instruction length, 1..15 bytes
// - disp_present in   1    current instruction carries a displacement
// - disp_pos     in   4    byte index of first displacement byte (legal 3..8)
// - disp_is32    in   1    1 = 32-bit displacement, 0 = 8-bit sign-extended
// - decode_adv   in   1    decode consumes current instruction (only while ir_valid)
// - IR           out  128  instruction window, registered
// - ir_valid     out  1    complete instruction at head: len_valid & instr_len <= cnt
// - disp_sel     out  3    displacement start select (table below)
// - disp_size    out  1    1 = 32-bit displacement, 0 = 8-bit
// - win_cnt      out  5    valid byte count 0..16
// BEHAVIOUR
// - Reset: IR=0, cnt=0, state=EMPTY, fetch_ready=1, ir_valid=0, disp_sel=000, disp_size=0.
// - fetch_ready = (cnt <= WIN_BYTES-FETCH_BYTES) & ~flush. It depends on registered cnt only,
//   not on decode_adv.
// - acc = fetch_valid & fetch_ready; con = decode_adv & ir_valid. A decode_adv without
//   ir_valid is ignored.
// - Next cnt = cnt - (con ? instr_len : 0) + (acc ? 8 : 0). Window shifts left by instr_len
//   bytes; chunk lands at byte (cnt - consumed). Vacated low bytes are zero-filled.
// - Simultaneous con & acc is legal and is resolved in one cycle.
// - flush has priority over everything: next cnt=0, IR=0, state=EMPTY. The same-cycle chunk
//   is dropped; fetch_ready=0 in that cycle.
// - FSM, registered, 2-bit:
//   - EMPTY: cnt==0.
//   - PARTIAL: cnt>0 and no full instruction.
//   - AVAIL: ir_valid possible.
//   - FULL: cnt > WIN_BYTES-FETCH_BYTES.
//   - Next state is computed from next cnt and is consistent with cnt at every edge.
// - ir_valid, disp_sel, disp_size are combinational from registered cnt and the decoder inputs.
//   Latency from fetch accept to ir_valid is 1 cycle.
// - disp_sel by disp_pos: 3->000, 4->001, 5->100, 6->101, 7->110, 8->111.
//   - disp_present=0 -> disp_sel=000, disp_size=0.
//   - Illegal disp_pos clamps: <3 -> 000, >8 -> 111.
// - disp_size = disp_present & disp_is32.
// - instr_len > 15 cannot occur. instr_len > cnt holds ir_valid low (wait for fill).
// - Reset asserted mid-operation returns every output to its reset value immediately.
// CONFIGURATION
// - IR_DISP_CHECK_EN defined: extra output disp_err (1 bit), registered and sticky until flush
//   or reset. It sets on con with disp_present and either:
//   - disp_pos < 3 or disp_pos > 8, or
//   - disp_pos + (disp_is32 ? 4 : 1) > instr_len.
// - IR_DISP_CHECK_EN undefined: no disp_err port; clamping only.
// STRUCTURE
// - Package ir_ctrl_pkg holds:
//   - state encodings EMPTY=00, PARTIAL=01, AVAIL=10, FULL=11;
//   - DISP_SEL_B3..DISP_SEL_B8 constants;
//   - WIN_BYTES and FETCH_BYTES defaults.
// - Sub-module ir_shift_align implements the byte left-shift by instr_len plus the chunk
//   insert at the fill offset, as a pure combinational next-IR function.
// - Top level holds the cnt/state registers, the handshakes and the disp_sel encoder.
// TESTING
// - Reset then 1 chunk 0x11..0x88 -> next cycle cnt=8, IR[127:64]=0x1122..88, state=PARTIAL.
// - cnt=8, len_valid, instr_len=6, decode_adv, plus a concurrent chunk -> cnt=10; old byte6
//   moves to byte0; the chunk lands at byte2.
// - Fill to cnt=16 -> fetch_ready=0, state=FULL. Consume len=9 -> cnt=7, fetch_ready=1.
// - Sweep disp_pos 3..8 with disp_is32 in {0,1} -> disp_sel per table, disp_size=disp_is32.
//   disp_pos=10 -> 111.
// - flush with cnt=12 and a concurrent valid chunk -> cnt=0, IR=0, state=EMPTY; chunk not
//   accepted.
// - IR_DISP_CHECK_EN: disp_pos=6, disp_is32=1, instr_len=8, consume -> disp_err=1 until flush.

Source files
------------

// File: rtl/ir_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ir_ctrl_pkg: shared types/constants for the instruction window  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package ir_ctrl_pkg;

  localparam int WIN_BYTES_DEF   = 16;
  localparam int FETCH_BYTES_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_AVAIL   = 2'b10,
    ST_FULL    = 2'b11
  } win_state_e;

  localparam logic [2:0] DISP_SEL_B3 = 3'b000;
  localparam logic [2:0] DISP_SEL_B4 = 3'b001;
  localparam logic [2:0] DISP_SEL_B5 = 3'b100;
  localparam logic [2:0] DISP_SEL_B6 = 3'b101;
  localparam logic [2:0] DISP_SEL_B7 = 3'b110;
  localparam logic [2:0] DISP_SEL_B8 = 3'b111;

  // Out-of-range positions clamp to the nearest legal select.
  function automatic logic [2:0] disp_sel_enc(input logic [3:0] pos);
    logic [2:0] sel;
    case (pos)
      4'd4:    sel = DISP_SEL_B4;
      4'd5:    sel = DISP_SEL_B5;
      4'd6:    sel = DISP_SEL_B6;
      4'd7:    sel = DISP_SEL_B7;
      default: sel = (pos < 4'd4) ? DISP_SEL_B3 : DISP_SEL_B8;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_shift_align.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ir_shift_align: next-window function (left shift + chunk insert)|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module ir_shift_align #(
  parameter int WIN_BYTES   = 16,
  parameter int FETCH_BYTES = 8,
  parameter int CW          = 5
) (
  input  logic [8*WIN_BYTES-1:0]   ir_cur,
  input  logic [CW-1:0]            shift_bytes,
  input  logic [CW-1:0]            fill_off,
  input  logic                     ins_en,
  input  logic [8*FETCH_BYTES-1:0] chunk,
  output logic [8*WIN_BYTES-1:0]   ir_next
);

  localparam int IRW = 8 * WIN_BYTES;
  localparam int FW  = 8 * FETCH_BYTES;

  logic [IRW-1:0] shifted;
  logic [IRW-1:0] placed;

  // Bytes above the fill count are always zero, so OR-merging the chunk is safe.
  always_comb begin
    shifted = ir_cur << {shift_bytes, 3'b000};
    placed  = '0;
    if (ins_en) begin
      placed = {chunk, {(IRW-FW){1'b0}}} >> {fill_off, 3'b000};
    end
    ir_next = shifted | placed;
  end

endmodule
`default_nettype wire

// File: rtl/ir_window_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ir_window_ctrl: 16-byte instruction window, fetch/retire control|
// | Optional IR_DISP_CHECK_EN adds sticky disp_err output.          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module ir_window_ctrl
  import ir_ctrl_pkg::*;
#(
  parameter int WIN_BYTES   = WIN_BYTES_DEF,
  parameter int FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic                             CLK,
  input  logic                             CLR,
  input  logic                             fetch_valid,
  input  logic [8*FETCH_BYTES-1:0]         fetch_data,
  output logic                             fetch_ready,
  input  logic                             flush,
  input  logic                             len_valid,
  input  logic [3:0]                       instr_len,
  input  logic                             disp_present,
  input  logic [3:0]                       disp_pos,
  input  logic                             disp_is32,
  input  logic                             decode_adv,
  output logic [8*WIN_BYTES-1:0]           IR,
  output logic                             ir_valid,
  output logic [2:0]                       disp_sel,
  output logic                             disp_size,
  output logic [$clog2(WIN_BYTES+1)-1:0]   win_cnt
`ifdef IR_DISP_CHECK_EN
  ,
  output logic                             disp_err
`endif
);

  localparam int            CW            = $clog2(WIN_BYTES + 1);
  localparam logic [CW-1:0] C_FETCH_BYTES = CW'(FETCH_BYTES);
  localparam logic [CW-1:0] C_FILL_LIMIT  = CW'(WIN_BYTES - FETCH_BYTES);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [8*WIN_BYTES-1:0] ir_q, ir_d, ir_aligned;
  win_state_e             state_q, state_d;
  logic [CW-1:0]          len_ext, consumed, fill_off;
  logic                   acc, con;

  assign len_ext = CW'(instr_len);

  // Outputs are forced to their reset values while CLR is low.
  always_comb begin
    fetch_ready = 1'b1;
    ir_valid    = 1'b0;
    disp_sel    = DISP_SEL_B3;
    disp_size   = 1'b0;
    if (CLR) begin
      fetch_ready = (state_q != ST_FULL) & ~flush;
      ir_valid    = len_valid & (len_ext <= cnt_q);
      if (disp_present) begin
        disp_sel  = disp_sel_enc(disp_pos);
        disp_size = disp_is32;
      end
    end
  end

  assign acc      = fetch_valid & fetch_ready;
  assign con      = decode_adv & ir_valid;
  assign consumed = con ? len_ext : '0;
  assign fill_off = cnt_q - consumed;

  ir_shift_align #(
    .WIN_BYTES   (WIN_BYTES),
    .FETCH_BYTES (FETCH_BYTES),
    .CW          (CW)
  ) u_align (
    .ir_cur      (ir_q),
    .shift_bytes (consumed),
    .fill_off    (fill_off),
    .ins_en      (acc),
    .chunk       (fetch_data),
    .ir_next     (ir_aligned)
  );

  always_comb begin
    cnt_d = cnt_q - consumed + (acc ? C_FETCH_BYTES : '0);
    ir_d  = ir_aligned;
    if (flush) begin
      cnt_d = '0;
      ir_d  = '0;
    end
  end

  // AVAIL only when the head instruction is unchanged and already fits next cycle.
  always_comb begin
    state_d = ST_PARTIAL;
    if (cnt_d == '0) begin
      state_d = ST_EMPTY;
    end else if (cnt_d > C_FILL_LIMIT) begin
      state_d = ST_FULL;
    end else if (~flush & ~con & len_valid & (len_ext <= cnt_d)) begin
      state_d = ST_AVAIL;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q   <= '0;
      ir_q    <= '0;
      state_q <= ST_EMPTY;
    end else begin
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      state_q <= state_d;
    end
  end

  assign IR      = ir_q;
  assign win_cnt = cnt_q;

`ifdef IR_DISP_CHECK_EN
  logic       disp_err_q, disp_err_d;
  logic [4:0] disp_end;

  always_comb begin
    disp_end   = {1'b0, disp_pos} + (disp_is32 ? 5'd4 : 5'd1);
    disp_err_d = disp_err_q;
    if (con & disp_present &
        ((disp_pos < 4'd3) | (disp_pos > 4'd8) | (disp_end > {1'b0, instr_len}))) begin
      disp_err_d = 1'b1;
    end
    if (flush) begin
      disp_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      disp_err_q <= 1'b0;
    end else begin
      disp_err_q <= disp_err_d;
    end
  end

  assign disp_err = disp_err_q;
`endif

endmodule
`default_nettype wire
